if_id_pipe_reg: RTL and testbench



---
 rtl/if_id_pipe_reg.sv | 96 +++++++++
 tb/tb_if_id_pipe_reg.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: holds the fetched instruction and PC+4 as one aligned snapshot.
// Supports stall (hold), flush/in_valid bubbles, and a saturating bubble counter.
module if_id_pipe_reg #(
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          BCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       Instruction,
    input  logic [PC_W-1:0]   Pcmas4_In,
    output logic              Valid,
    output logic [31:0]       Instr_q,
    output logic [PC_W-1:0]   Pcmas4,
    output logic [3:0]        OpCode,
    output logic [1:0]        Cond,
    output logic [1:0]        F,
    output logic [3:0]        Rg,
    output logic [3:0]        Rp,
    output logic [3:0]        Rs,
    output logic [15:0]       Inm,
    output logic [23:0]       Label,
    output logic [BCNT_W-1:0] Bubble_cnt
);

    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [BCNT_W-1:0] bcnt_q,  bcnt_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [BCNT_W-1:0] sat_inc(input logic [BCNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + BCNT_W'(1);
        end
    endfunction

    // Next-state selection; flush outranks stall so a squash is never held off.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        bcnt_d  = bcnt_q;
        if (flush || (!stall && !in_valid)) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = '0;
            bcnt_d  = sat_inc(bcnt_q);
        end else if (stall) begin
            valid_d = valid_q;
            instr_d = instr_q;
            pc_d    = pc_q;
            bcnt_d  = bcnt_q;
        end else begin
            valid_d = 1'b1;
            instr_d = Instruction;
            pc_d    = Pcmas4_In;
            bcnt_d  = bcnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            bcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign Valid      = valid_q;
    assign Instr_q    = instr_q;
    assign Pcmas4     = pc_q;
    assign Bubble_cnt = bcnt_q;
    // Overlapping decode fields; decode picks the relevant ones by OpCode.
    assign OpCode     = instr_q[31:28];
    assign Cond       = instr_q[27:26];
    assign F          = instr_q[25:24];
    assign Rg         = instr_q[23:20];
    assign Rp         = instr_q[19:16];
    assign Rs         = instr_q[15:12];
    assign Inm        = instr_q[15:0];
    assign Label      = instr_q[23:0];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed self-checking bench for if_id_pipe_reg, including a BCNT_W=2 instance for saturation.
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic        rst2, flush2;
    logic [31:0] instruction, pc_in;

    logic        valid_s;
    logic [31:0] instr_s, pc_s;
    logic [3:0]  opcode_s, rg_s, rp_s, rs_s;
    logic [1:0]  cond_s, f_s;
    logic [15:0] inm_s, bcnt_s;
    logic [23:0] label_s;

    logic        valid2_s;
    logic [31:0] instr2_s, pc2_s;
    logic [3:0]  opcode2_s, rg2_s, rp2_s, rs2_s;
    logic [1:0]  cond2_s, f2_s;
    logic [15:0] inm2_s;
    logic [23:0] label2_s;
    logic [1:0]  bcnt2_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_id_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .Instruction(instruction), .Pcmas4_In(pc_in),
        .Valid(valid_s), .Instr_q(instr_s), .Pcmas4(pc_s),
        .OpCode(opcode_s), .Cond(cond_s), .F(f_s), .Rg(rg_s), .Rp(rp_s), .Rs(rs_s),
        .Inm(inm_s), .Label(label_s), .Bubble_cnt(bcnt_s)
    );

    if_id_pipe_reg #(.BCNT_W(2)) dut_sat (
        .clk(clk), .rst(rst2), .stall(1'b0), .flush(flush2), .in_valid(in_valid),
        .Instruction(instruction), .Pcmas4_In(pc_in),
        .Valid(valid2_s), .Instr_q(instr2_s), .Pcmas4(pc2_s),
        .OpCode(opcode2_s), .Cond(cond2_s), .F(f2_s), .Rg(rg2_s), .Rp(rp2_s), .Rs(rs2_s),
        .Inm(inm2_s), .Label(label2_s), .Bubble_cnt(bcnt2_s)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; flush = 1'b0; flush2 = 1'b0;
        in_valid = 1'b1; instruction = 32'hFFFF_FFFF; pc_in = 32'h0000_0050;
        tick(); tick();
        check_val("rst_valid", {63'd0, valid_s}, 64'd0);
        check_val("rst_instr", {32'd0, instr_s}, 64'd0);
        check_val("rst_pc",    {32'd0, pc_s},    64'd0);
        check_val("rst_bcnt",  {48'd0, bcnt_s},  64'd0);
        check_val("rst_label", {40'd0, label_s}, 64'd0);

        rst = 1'b0;
        tick();
        check_val("post_rst_valid", {63'd0, valid_s}, 64'd1);
        check_val("post_rst_instr", {32'd0, instr_s}, 64'hFFFF_FFFF);
        check_val("post_rst_pc",    {32'd0, pc_s},    64'h50);

        instruction = 32'h1A5C_3BEE; pc_in = 32'h0000_0104;
        #2;
        check_val("pre_edge_instr",  {32'd0, instr_s},  64'hFFFF_FFFF);
        check_val("pre_edge_opcode", {60'd0, opcode_s}, 64'hF);
        tick();
        check_val("opcode", {60'd0, opcode_s}, 64'h1);
        check_val("cond",   {62'd0, cond_s},   64'h2);
        check_val("f",      {62'd0, f_s},      64'h2);
        check_val("rg",     {60'd0, rg_s},     64'h5);
        check_val("rp",     {60'd0, rp_s},     64'hC);
        check_val("rs",     {60'd0, rs_s},     64'h3);
        check_val("inm",    {48'd0, inm_s},    64'h3BEE);
        check_val("label",  {40'd0, label_s},  64'h5C_3BEE);
        check_val("pc104",  {32'd0, pc_s},     64'h104);

        instruction = 32'h2000_0010; pc_in = 32'h0000_0200;
        tick();
        check_val("stall_load", {32'd0, instr_s}, 64'h2000_0010);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instruction = 32'hDEAD_0000 + 32'(i);
            pc_in = 32'h0000_0900 + 32'(i);
            tick();
            check_val("stall_instr", {32'd0, instr_s}, 64'h2000_0010);
            check_val("stall_pc",    {32'd0, pc_s},    64'h200);
            check_val("stall_valid", {63'd0, valid_s}, 64'd1);
            check_val("stall_bcnt",  {48'd0, bcnt_s},  64'd0);
        end
        stall = 1'b0; instruction = 32'h3000_0020; pc_in = 32'h0000_0300;
        tick();
        check_val("unstall_instr", {32'd0, instr_s}, 64'h3000_0020);
        check_val("unstall_pc",    {32'd0, pc_s},    64'h300);

        flush = 1'b1; stall = 1'b1;
        tick();
        check_val("flush_valid", {63'd0, valid_s}, 64'd0);
        check_val("flush_instr", {32'd0, instr_s}, 64'd0);
        check_val("flush_pc",    {32'd0, pc_s},    64'd0);
        check_val("flush_bcnt",  {48'd0, bcnt_s},  64'd1);
        flush = 1'b0; stall = 1'b0;

        rst = 1'b1;
        tick();
        check_val("rst2_bcnt", {48'd0, bcnt_s}, 64'd0);
        rst = 1'b0; in_valid = 1'b0; instruction = 32'h4444_5555; pc_in = 32'h0000_0400;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_val("inv_valid", {63'd0, valid_s}, 64'd0);
            check_val("inv_instr", {32'd0, instr_s}, 64'd0);
            check_val("inv_bcnt",  {48'd0, bcnt_s},  64'(i));
        end
        stall = 1'b1;
        tick();
        check_val("inv_stall_bcnt", {48'd0, bcnt_s}, 64'd3);
        stall = 1'b0; in_valid = 1'b1;
        tick();
        check_val("reload_valid", {63'd0, valid_s}, 64'd1);
        check_val("reload_instr", {32'd0, instr_s}, 64'h4444_5555);
        check_val("reload_bcnt",  {48'd0, bcnt_s},  64'd3);

        rst2 = 1'b0; flush2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("sat_bcnt",  {62'd0, bcnt2_s},  (i < 3) ? 64'(i + 1) : 64'd3);
            check_val("sat_valid", {63'd0, valid2_s}, 64'd0);
        end
        flush2 = 1'b0; rst2 = 1'b1;
        tick();
        check_val("sat_rst_bcnt", {62'd0, bcnt2_s}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
